// File: rtl/sr_response_checker.sv
// Checks three SR flip-flop realisations (JK-, D-, T-based) against an internal SR reference model.
// Results are registered one clock after the sampled edge; there is no backpressure, every valid sample is consumed.
// Optional first-mismatch snapshot outputs are enabled by defining SR_CHECK_SNAPSHOT_EN.
module sr_response_checker #(
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 8,
    parameter int SR11_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             s,
    input  logic             r,
    input  logic             q_jk,
    input  logic             q_d,
    input  logic             q_t,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [2:0]       fail_mask
`ifdef SR_CHECK_SNAPSHOT_EN
    ,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_idx,
    output logic [5:0]       snap_bus
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]       fail_mask_q, fail_mask_d;
    logic             exp_q_q, exp_q_d;
    logic             skip_q, skip_d;

    logic             in_run;
    logic             skip_cur;
    logic [2:0]       mism;

`ifdef SR_CHECK_SNAPSHOT_EN
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_idx_q, snap_idx_d;
    logic [5:0]       snap_bus_q, snap_bus_d;
`endif

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        sample_cnt_d = sample_cnt_q;
        fail_mask_d  = fail_mask_q;
        exp_q_d      = exp_q_q;
        skip_d       = skip_q;
        in_run       = (state_q == ST_RUN) || start;
        skip_cur     = 1'b0;
        mism         = 3'b000;
`ifdef SR_CHECK_SNAPSHOT_EN
        snap_valid_d = snap_valid_q;
        snap_idx_d   = snap_idx_q;
        snap_bus_d   = snap_bus_q;
`endif

        // A start wipes the run state first so a same-edge sample lands in the new run.
        if (start) begin
            state_d      = ST_RUN;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            err_cnt_d    = '0;
            sample_cnt_d = '0;
            fail_mask_d  = 3'b000;
            skip_d       = 1'b0;
`ifdef SR_CHECK_SNAPSHOT_EN
            snap_valid_d = 1'b0;
            snap_idx_d   = '0;
            snap_bus_d   = 6'b000000;
`endif
        end

        skip_cur = skip_d;

        if (sample_valid) begin
            if (in_run) begin
                if (!skip_cur) begin
                    mism        = {q_jk, q_d, q_t} ^ {3{exp_q_q}};
                    fail_mask_d = fail_mask_d | mism;
                    if ((|mism) && (err_cnt_d != CNT_MAX)) begin
                        err_cnt_d = err_cnt_d + 1'b1;
                    end
`ifdef SR_CHECK_SNAPSHOT_EN
                    if ((|mism) && !snap_valid_d) begin
                        snap_valid_d = 1'b1;
                        snap_idx_d   = sample_cnt_d;
                        snap_bus_d   = {s, r, exp_q_q, q_jk, q_d, q_t};
                    end
`endif
                end
                sample_cnt_d = sample_cnt_d + 1'b1;
                if (sample_cnt_d == RUN_LEN) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end
            end

            // The model keeps tracking outside a run so it stays aligned with the flip-flop.
            skip_d = 1'b0;
            case ({s, r})
                2'b01:   exp_q_d = 1'b0;
                2'b10:   exp_q_d = 1'b1;
                2'b11: begin
                    if (SR11_MODE == 1) begin
                        exp_q_d = ~exp_q_q;
                    end else if (SR11_MODE == 2) begin
                        skip_d = 1'b1;
                    end
                end
                default: exp_q_d = exp_q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
            fail_mask_q  <= 3'b000;
            exp_q_q      <= 1'b0;
            skip_q       <= 1'b0;
`ifdef SR_CHECK_SNAPSHOT_EN
            snap_valid_q <= 1'b0;
            snap_idx_q   <= '0;
            snap_bus_q   <= 6'b000000;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            fail_mask_q  <= fail_mask_d;
            exp_q_q      <= exp_q_d;
            skip_q       <= skip_d;
`ifdef SR_CHECK_SNAPSHOT_EN
            snap_valid_q <= snap_valid_d;
            snap_idx_q   <= snap_idx_d;
            snap_bus_q   <= snap_bus_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign sample_cnt = sample_cnt_q;
    assign fail_mask  = fail_mask_q;
`ifdef SR_CHECK_SNAPSHOT_EN
    assign snap_valid = snap_valid_q;
    assign snap_idx   = snap_idx_q;
    assign snap_bus   = snap_bus_q;
`endif

endmodule

// File: tb/tb_sr_response_checker.sv
// Bench for sr_response_checker: u0 default config (hold on S=R=1), u1 with 4-bit counters, 15-sample runs, don't-care on S=R=1.
module tb_sr_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st0, v0, s0, r0, qj0, qd0, qt0;
    logic busy0, done0, pass0;
    logic [7:0] err0, cnt0;
    logic [2:0] mask0;
    logic st1, v1, s1, r1, qj1, qd1, qt1;
    logic busy1, done1, pass1;
    logic [3:0] err1, cnt1;
    logic [2:0] mask1;
`ifdef SR_CHECK_SNAPSHOT_EN
    logic sv0, sv1;
    logic [7:0] si0;
    logic [3:0] si1;
    logic [5:0] sb0, sb1;
`endif

    sr_response_checker u0 (
        .clk(clk), .rst(rst), .start(st0), .sample_valid(v0), .s(s0), .r(r0),
        .q_jk(qj0), .q_d(qd0), .q_t(qt0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .sample_cnt(cnt0), .fail_mask(mask0)
`ifdef SR_CHECK_SNAPSHOT_EN
        , .snap_valid(sv0), .snap_idx(si0), .snap_bus(sb0)
`endif
    );

    sr_response_checker #(.NUM_SAMPLES(15), .CNT_W(4), .SR11_MODE(2)) u1 (
        .clk(clk), .rst(rst), .start(st1), .sample_valid(v1), .s(s1), .r(r1),
        .q_jk(qj1), .q_d(qd1), .q_t(qt1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .sample_cnt(cnt1), .fail_mask(mask1)
`ifdef SR_CHECK_SNAPSHOT_EN
        , .snap_valid(sv1), .snap_idx(si1), .snap_bus(sb1)
`endif
    );

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [7:0] cnt;
        logic [2:0] mask;
        logic       sv;
        logic [7:0] si;
        logic [5:0] sb;
    } rec_t;

    rec_t sb_u0[$];
    rec_t sb_u1[$];
    int total = 0;
    int bad   = 0;
    logic g0 = 1'b0;
    logic g1 = 1'b0;
    logic [1:0] pat[4] = '{2'b00, 2'b01, 2'b10, 2'b00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic p, input int e, input int c, input logic [2:0] m,
                                input logic v, input int i, input logic [5:0] b);
        rec_t x;
        x.pass = p; x.err = 8'(e); x.cnt = 8'(c); x.mask = m;
        x.sv = v; x.si = 8'(i); x.sb = b;
        return x;
    endfunction

    // Correct SR flip-flop behaviour with S=R=1 holding.
    function automatic logic nxt(input logic g, input logic s, input logic r);
        case ({s, r})
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return g;
        endcase
    endfunction

    task automatic d0(input logic st, input logic v, input logic s, input logic r, input logic [2:0] flip);
        @(negedge clk);
        st0 = st; v0 = v; s0 = s; r0 = r;
        {qj0, qd0, qt0} = {3{g0}} ^ flip;
        @(posedge clk);
        if (v && rst) g0 = nxt(g0, s, r);
    endtask

    task automatic d1(input logic st, input logic v, input logic s, input logic r, input logic [2:0] flip);
        @(negedge clk);
        st1 = st; v1 = v; s1 = s; r1 = r;
        {qj1, qd1, qt1} = {3{g1}} ^ flip;
        @(posedge clk);
        if (v && rst) g1 = nxt(g1, s, r);
    endtask

    logic dp0 = 1'b0;
    logic dp1 = 1'b0;

    always @(negedge clk) begin
        rec_t e;
        if (done0 && !dp0) begin
            if (sb_u0.size() == 0) begin
                chk("u0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_u0.pop_front();
                chk("u0_pass", 32'(pass0), 32'(e.pass));
                chk("u0_err_cnt", 32'(err0), 32'(e.err));
                chk("u0_sample_cnt", 32'(cnt0), 32'(e.cnt));
                chk("u0_fail_mask", 32'(mask0), 32'(e.mask));
                chk("u0_busy_done", 32'(busy0), 32'd0);
`ifdef SR_CHECK_SNAPSHOT_EN
                chk("u0_snap_valid", 32'(sv0), 32'(e.sv));
                chk("u0_snap_idx", 32'(si0), 32'(e.si));
                chk("u0_snap_bus", 32'(sb0), 32'(e.sb));
`endif
            end
        end
        dp0 = done0;
    end

    always @(negedge clk) begin
        rec_t e;
        if (done1 && !dp1) begin
            if (sb_u1.size() == 0) begin
                chk("u1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_u1.pop_front();
                chk("u1_pass", 32'(pass1), 32'(e.pass));
                chk("u1_err_cnt", 32'(err1), 32'(e.err));
                chk("u1_sample_cnt", 32'(cnt1), 32'(e.cnt));
                chk("u1_fail_mask", 32'(mask1), 32'(e.mask));
                chk("u1_busy_done", 32'(busy1), 32'd0);
`ifdef SR_CHECK_SNAPSHOT_EN
                chk("u1_snap_valid", 32'(sv1), 32'(e.sv));
                chk("u1_snap_idx", 32'(si1), 32'(e.si));
                chk("u1_snap_bus", 32'(sb1), 32'(e.sb));
`endif
            end
        end
        dp1 = done1;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst = 1'b0;
        {st0, v0, s0, r0, qj0, qd0, qt0} = '0;
        {st1, v1, s1, r1, qj1, qd1, qt1} = '0;
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_pass", 32'(pass0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_mask", 32'(mask0), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Run A: clean 00,01,10,00 cycle.
        sb_u0.push_back(mk(1'b1, 0, 16, 3'b000, 1'b0, 0, 6'b000000));
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 16; i++) begin
            d0(1'b0, 1'b1, pat[i % 4][1], pat[i % 4][0], 3'b000);
            if (i == 7) begin
                #1 chk("u0_busy_run", 32'(busy0), 32'd1);
                chk("u0_cnt_mid", 32'(cnt0), 32'd8);
            end
        end
        d0(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Run B: 10,11,11 with a flip-flop that holds on 11.
        sb_u0.push_back(mk(1'b1, 0, 16, 3'b000, 1'b0, 0, 6'b000000));
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        for (int i = 0; i < 13; i++) d0(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Run C: q_t toggles on every 11 edge, so it is wrong after the 1st and 3rd toggle.
        sb_u0.push_back(mk(1'b0, 2, 16, 3'b001, 1'b1, 2, 6'b111110));
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b001);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        d0(1'b0, 1'b1, 1'b1, 1'b1, 3'b001);
        d0(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        for (int i = 0; i < 10; i++) d0(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);

        // Run D: a set while done (tracked, not counted), then q_jk stuck at 0.
        d0(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        #1 chk("u0_done_no_count", 32'(cnt0), 32'd16);
        sb_u0.push_back(mk(1'b0, 16, 16, 3'b100, 1'b1, 0, 6'b101011));
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 16; i++) d0(1'b0, 1'b1, 1'b1, 1'b0, 3'b100);

        // Run F: aborted by a restart that carries its own first sample.
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) d0(1'b0, 1'b1, 1'b0, 1'b1, 3'b010);
        sb_u0.push_back(mk(1'b1, 0, 16, 3'b000, 1'b0, 0, 6'b000000));
        for (int i = 0; i < 16; i++) d0(i == 0, 1'b1, pat[i % 4][1], pat[i % 4][0], 3'b000);

        // Run E: asynchronous reset during the 5th sample, then a fresh run.
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) d0(1'b0, 1'b1, pat[i % 4][1], pat[i % 4][0], 3'b000);
        @(negedge clk);
        v0 = 1'b1; s0 = 1'b0; r0 = 1'b0; {qj0, qd0, qt0} = {3{g0}};
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_pass", 32'(pass0), 32'd0);
        chk("arst_err", 32'(err0), 32'd0);
        chk("arst_cnt", 32'(cnt0), 32'd0);
        chk("arst_mask", 32'(mask0), 32'd0);
`ifdef SR_CHECK_SNAPSHOT_EN
        chk("arst_snap_valid", 32'(sv0), 32'd0);
`endif
        @(posedge clk);
        g0 = 1'b0;
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0;
        sb_u0.push_back(mk(1'b1, 0, 16, 3'b000, 1'b0, 0, 6'b000000));
        for (int i = 0; i < 16; i++) d0(i == 0, 1'b1, pat[i % 4][1], pat[i % 4][0], 3'b000);

        // Run G: first mismatch at index 3 (S=0,R=1, exp 0, q_d=1), a later one must not overwrite it.
        sb_u0.push_back(mk(1'b0, 2, 16, 3'b010, 1'b1, 3, 6'b010010));
        d0(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
        d0(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b1, 1'b0, 1'b1, 3'b010);
        d0(1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
        for (int i = 0; i < 11; i++) d0(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        d0(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Run H (u1): every channel wrong on all 15 samples; 4-bit counter tops out at 15.
        sb_u1.push_back(mk(1'b0, 15, 15, 3'b111, 1'b1, 0, 6'b100111));
        d1(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 15; i++) d1(1'b0, 1'b1, 1'b1, 1'b0, 3'b111);
        d1(1'b0, 1'b1, 1'b1, 1'b0, 3'b111);
        d1(1'b0, 1'b1, 1'b1, 1'b0, 3'b111);
        #1;
        chk("u1_err_sat", 32'(err1), 32'd15);
        chk("u1_cnt_hold", 32'(cnt1), 32'd15);
        chk("u1_done_hold", 32'(done1), 32'd1);

        // Run I (u1): sample after 11 is not compared even though its Q is wrong.
        sb_u1.push_back(mk(1'b1, 0, 15, 3'b000, 1'b0, 0, 6'b000000));
        d1(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        d1(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
        d1(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
        d1(1'b0, 1'b1, 1'b0, 1'b0, 3'b111);
        for (int i = 0; i < 12; i++) d1(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
        d1(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        repeat (3) @(negedge clk);
        chk("u0_scoreboard_drained", 32'(sb_u0.size()), 32'd0);
        chk("u1_scoreboard_drained", 32'(sb_u1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
